// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared constants and types for the 5-stage MIPS core:
//               ALUOp width and encodings, the zero register index and the
//               decoded control bundle carried from ID into EX.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int ALUOP_W = 2;

  // ALUOp encodings driven by the main decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 2'b00;  // lw / sw / addi
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;  // beq / bne subtract
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;  // funct field decides
  localparam logic [ALUOP_W-1:0] ALUOP_IMM    = 2'b11;  // logical immediates

  // Register $0 is hard-wired to zero and never produces a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Decoded control bundle; a bubble is simply this struct cleared to zero
  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detection. Raises luh when the
//               load sitting in EX writes a register that the instruction in
//               ID reads, and freezes PC and IF/ID unless a flush overrides
//               the stall or a global hold is already freezing everything.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              flush,
  input  logic              hold,
  output logic              luh,
  output logic              pc_write,
  output logic              if_id_write
);
  import mips_pkg::*;

  logic rs_match;
  logic rt_match;

  // Detect a load in EX feeding a source operand of the instruction in ID
  always_comb begin
    rs_match    = id_use_rs && (ex_dest == id_rs);
    rt_match    = id_use_rt && (ex_dest == id_rt);
    luh         = ex_mem_read && (ex_dest != REG_ZERO) && (rs_match || rt_match);
    // A flush redirects the PC, so a stall must not block it
    pc_write    = !(luh && !flush) && !hold;
    if_id_write = pc_write;
  end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with integrated load-use hazard
//               detection. Captures decoded controls, operands and register
//               addresses from ID, and inserts a bubble on flush or load-use.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               flush,
  input  logic [REG_AW-1:0]  IF_ID_RS,
  input  logic [REG_AW-1:0]  IF_ID_RT,
  input  logic [REG_AW-1:0]  IF_ID_RD,
  input  logic               ID_UseRS,
  input  logic               ID_UseRT,
  input  logic               ID_RegWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PC4,
  output logic [REG_AW-1:0]  ID_EX_RS,
  output logic [REG_AW-1:0]  ID_EX_RT,
  output logic               ID_EX_UseRS,
  output logic               ID_EX_UseRT,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_ALUSrc,
  output logic               ID_EX_RegDst,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [DATA_W-1:0]  ID_EX_ReadData1,
  output logic [DATA_W-1:0]  ID_EX_ReadData2,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic [DATA_W-1:0]  ID_EX_PC4,
  output logic [REG_AW-1:0]  ID_EX_RegWriteAdd,
  output logic               PC_Write,
  output logic               IF_ID_Write,
  output logic               ID_EX_Bubble
);
  import mips_pkg::*;

  ctrl_t              id_ctrl;
  ctrl_t              ex_ctrl;
  logic [REG_AW-1:0]  id_dest;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_dest;
  logic               ex_use_rs;
  logic               ex_use_rt;
  logic [DATA_W-1:0]  ex_rd1;
  logic [DATA_W-1:0]  ex_rd2;
  logic [DATA_W-1:0]  ex_imm;
  logic [DATA_W-1:0]  ex_pc4;
  logic               ex_bubble;
  logic               luh;
  logic               insert_bubble;

  // Bundle the decoded controls and resolve the destination register in ID
  always_comb begin
    id_ctrl            = CTRL_NOP;
    id_ctrl.reg_write  = ID_RegWrite;
    id_ctrl.mem_to_reg = ID_MemtoReg;
    id_ctrl.mem_read   = ID_MemRead;
    id_ctrl.mem_write  = ID_MemWrite;
    id_ctrl.alu_src    = ID_ALUSrc;
    id_ctrl.reg_dst    = ID_RegDst;
    id_ctrl.alu_op     = ID_ALUOp;
    id_dest            = ID_RegDst ? IF_ID_RD : IF_ID_RT;
    insert_bubble      = flush || luh;
  end

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_dest     (ex_dest),
    .id_rs       (IF_ID_RS),
    .id_rt       (IF_ID_RT),
    .id_use_rs   (ID_UseRS),
    .id_use_rt   (ID_UseRT),
    .flush       (flush),
    .hold        (hold),
    .luh         (luh),
    .pc_write    (PC_Write),
    .if_id_write (IF_ID_Write)
  );

  // ID/EX register bank: reset > hold > bubble (flush or load-use) > load
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl   <= CTRL_NOP;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dest   <= '0;
      ex_use_rs <= 1'b0;
      ex_use_rt <= 1'b0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      ex_bubble <= 1'b1;
    end else if (!hold) begin
      if (insert_bubble) begin
        // Zero dest keeps the forward unit from ever matching a bubble
        ex_ctrl   <= CTRL_NOP;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_dest   <= '0;
        ex_use_rs <= 1'b0;
        ex_use_rt <= 1'b0;
        ex_rd1    <= '0;
        ex_rd2    <= '0;
        ex_imm    <= '0;
        ex_pc4    <= '0;
        ex_bubble <= 1'b1;
      end else begin
        ex_ctrl   <= id_ctrl;
        ex_rs     <= IF_ID_RS;
        ex_rt     <= IF_ID_RT;
        ex_dest   <= id_dest;
        ex_use_rs <= ID_UseRS;
        ex_use_rt <= ID_UseRT;
        ex_rd1    <= ID_ReadData1;
        ex_rd2    <= ID_ReadData2;
        ex_imm    <= ID_Imm;
        ex_pc4    <= ID_PC4;
        ex_bubble <= 1'b0;
      end
    end
  end

  // Drive the EX-side outputs straight from the register bank
  always_comb begin
    ID_EX_RS          = ex_rs;
    ID_EX_RT          = ex_rt;
    ID_EX_UseRS       = ex_use_rs;
    ID_EX_UseRT       = ex_use_rt;
    ID_EX_RegWrite    = ex_ctrl.reg_write;
    ID_EX_MemtoReg    = ex_ctrl.mem_to_reg;
    ID_EX_MemRead     = ex_ctrl.mem_read;
    ID_EX_MemWrite    = ex_ctrl.mem_write;
    ID_EX_ALUSrc      = ex_ctrl.alu_src;
    ID_EX_RegDst      = ex_ctrl.reg_dst;
    ID_EX_ALUOp       = ex_ctrl.alu_op;
    ID_EX_ReadData1   = ex_rd1;
    ID_EX_ReadData2   = ex_rd2;
    ID_EX_Imm         = ex_imm;
    ID_EX_PC4         = ex_pc4;
    ID_EX_RegWriteAdd = ex_dest;
    ID_EX_Bubble      = ex_bubble;
  end

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. Each cycle the expected
//               EX-stage contents are queued when ID is driven and compared
//               after the clock edge; PC/IF-ID write enables are checked
//               combinationally before the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic [4:0]  IF_ID_RS, IF_ID_RT, IF_ID_RD;
  logic        ID_UseRS, ID_UseRT, ID_RegWrite, ID_MemtoReg, ID_MemRead;
  logic        ID_MemWrite, ID_ALUSrc, ID_RegDst;
  logic [1:0]  ID_ALUOp;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4;
  logic [4:0]  ID_EX_RS, ID_EX_RT, ID_EX_RegWriteAdd;
  logic        ID_EX_UseRS, ID_EX_UseRT, ID_EX_RegWrite, ID_EX_MemtoReg;
  logic        ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc, ID_EX_RegDst;
  logic [1:0]  ID_EX_ALUOp;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC4;
  logic        PC_Write, IF_ID_Write, ID_EX_Bubble;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        bubble;
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rd1;
  } exp_t;

  exp_t sb[$];

  id_ex_stage dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .IF_ID_RS(IF_ID_RS), .IF_ID_RT(IF_ID_RT), .IF_ID_RD(IF_ID_RD),
    .ID_UseRS(ID_UseRS), .ID_UseRT(ID_UseRT),
    .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_ALUOp(ID_ALUOp),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PC4(ID_PC4),
    .ID_EX_RS(ID_EX_RS), .ID_EX_RT(ID_EX_RT),
    .ID_EX_UseRS(ID_EX_UseRS), .ID_EX_UseRT(ID_EX_UseRT),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDst(ID_EX_RegDst),
    .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC4(ID_EX_PC4),
    .ID_EX_RegWriteAdd(ID_EX_RegWriteAdd),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Bubble(ID_EX_Bubble)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_nop();
    {IF_ID_RS, IF_ID_RT, IF_ID_RD} = '0;
    {ID_UseRS, ID_UseRT, ID_RegWrite, ID_MemtoReg, ID_MemRead} = '0;
    {ID_MemWrite, ID_ALUSrc, ID_RegDst} = '0;
    ID_ALUOp = 2'b00;
    ID_ReadData1 = '0; ID_ReadData2 = '0; ID_Imm = '0; ID_PC4 = '0;
  endtask

  task automatic set_lw(input logic [4:0] dst, input logic [4:0] base);
    set_nop();
    IF_ID_RS = base; IF_ID_RT = dst;
    ID_UseRS = 1'b1; ID_RegWrite = 1'b1; ID_MemtoReg = 1'b1;
    ID_MemRead = 1'b1; ID_ALUSrc = 1'b1;
    ID_ReadData1 = 32'hA000_0000 | 32'(base);
    ID_ReadData2 = 32'hB000_0000 | 32'(dst);
    ID_PC4 = 32'h0000_0104;
  endtask

  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    IF_ID_RS = rs; IF_ID_RT = rt; IF_ID_RD = rd;
    ID_UseRS = 1'b1; ID_UseRT = 1'b1; ID_RegWrite = 1'b1;
    ID_RegDst = 1'b1; ID_ALUOp = 2'b10;
    ID_ReadData1 = 32'hA000_0000 | 32'(rs);
    ID_ReadData2 = 32'hB000_0000 | 32'(rt);
    ID_PC4 = 32'h0000_0108;
  endtask

  // addi-style: rt is the destination and is not read
  task automatic set_addi(input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    IF_ID_RS = rs; IF_ID_RT = rt;
    ID_UseRS = 1'b1; ID_RegWrite = 1'b1; ID_ALUSrc = 1'b1;
    ID_Imm = 32'd1;
    ID_ReadData1 = 32'hA000_0000 | 32'(rs);
    ID_PC4 = 32'h0000_010C;
  endtask

  // ---------------- expected EX contents ----------------
  function automatic exp_t e_bub();
    exp_t e;
    e.bubble = 1'b1; e.reg_write = 1'b0; e.mem_read = 1'b0;
    e.rs = '0; e.rt = '0; e.dest = '0; e.rd1 = '0;
    return e;
  endfunction

  function automatic exp_t e_lw(input logic [4:0] dst, input logic [4:0] base);
    exp_t e;
    e.bubble = 1'b0; e.reg_write = 1'b1; e.mem_read = 1'b1;
    e.rs = base; e.rt = dst; e.dest = dst; e.rd1 = 32'hA000_0000 | 32'(base);
    return e;
  endfunction

  function automatic exp_t e_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    e.bubble = 1'b0; e.reg_write = 1'b1; e.mem_read = 1'b0;
    e.rs = rs; e.rt = rt; e.dest = rd; e.rd1 = 32'hA000_0000 | 32'(rs);
    return e;
  endfunction

  function automatic exp_t e_addi(input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    e.bubble = 1'b0; e.reg_write = 1'b1; e.mem_read = 1'b0;
    e.rs = rs; e.rt = rt; e.dest = rt; e.rd1 = 32'hA000_0000 | 32'(rs);
    return e;
  endfunction

  // One pipeline cycle: check write enables before the edge, queue the
  // expected EX state, then pop and compare it after the edge.
  task automatic cycle(input string tag, input logic exp_pcw, input exp_t e);
    exp_t x;
    #1;
    check({tag, ".PC_Write"}, 32'(PC_Write), 32'(exp_pcw));
    check({tag, ".IF_ID_Write"}, 32'(IF_ID_Write), 32'(exp_pcw));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({tag, ".Bubble"},   32'(ID_EX_Bubble),      32'(x.bubble));
      check({tag, ".RegWrite"}, 32'(ID_EX_RegWrite),    32'(x.reg_write));
      check({tag, ".MemRead"},  32'(ID_EX_MemRead),     32'(x.mem_read));
      check({tag, ".RS"},       32'(ID_EX_RS),          32'(x.rs));
      check({tag, ".RT"},       32'(ID_EX_RT),          32'(x.rt));
      check({tag, ".Dest"},     32'(ID_EX_RegWriteAdd), 32'(x.dest));
      check({tag, ".RD1"},      ID_EX_ReadData1,        x.rd1);
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    set_nop();
    @(posedge clk);
    #1;
    // Reset state
    check("rst.Bubble",   32'(ID_EX_Bubble),      32'd1);
    check("rst.RegWrite", 32'(ID_EX_RegWrite),    32'd0);
    check("rst.MemRead",  32'(ID_EX_MemRead),     32'd0);
    check("rst.Dest",     32'(ID_EX_RegWriteAdd), 32'd0);
    check("rst.PC_Write", 32'(PC_Write),          32'd1);
    check("rst.IF_ID_Write", 32'(IF_ID_Write),    32'd1);
    rst = 1'b0;

    // 1. lw $2,0($1); add $3,$2,$4 -> one stall cycle, then add enters EX
    set_lw(5'd2, 5'd1);          cycle("t1.lw",    1'b1, e_lw(5'd2, 5'd1));
    set_add(5'd3, 5'd2, 5'd4);   cycle("t1.stall", 1'b0, e_bub());
                                 cycle("t1.add",   1'b1, e_add(5'd3, 5'd2, 5'd4));

    // 2. load writing $0 never stalls
    set_lw(5'd0, 5'd1);          cycle("t2.lw",    1'b1, e_lw(5'd0, 5'd1));
    set_add(5'd3, 5'd0, 5'd4);   cycle("t2.add",   1'b1, e_add(5'd3, 5'd0, 5'd4));

    // 3. rt matches the load but is not read -> no stall
    set_lw(5'd2, 5'd1);          cycle("t3.lw",    1'b1, e_lw(5'd2, 5'd1));
    set_addi(5'd5, 5'd2);        cycle("t3.addi",  1'b1, e_addi(5'd5, 5'd2));

    // 4. luh together with flush -> flush wins, no repeated stall
    set_lw(5'd2, 5'd1);          cycle("t4.lw",    1'b1, e_lw(5'd2, 5'd1));
    set_add(5'd3, 5'd2, 5'd4);
    flush = 1'b1;                cycle("t4.flush", 1'b1, e_bub());
    flush = 1'b0;                cycle("t4.next",  1'b1, e_add(5'd3, 5'd2, 5'd4));

    // 5. hold for 3 cycles: EX frozen, PC held; loads after hold drops
    set_add(5'd7, 5'd8, 5'd9);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("t5.hold%0d", i), 1'b0, e_add(5'd3, 5'd2, 5'd4));
    end
    hold = 1'b0;                 cycle("t5.load",  1'b1, e_add(5'd7, 5'd8, 5'd9));

    // 6. reset during a load-use stall -> bubble, no residual stall
    set_lw(5'd2, 5'd1);          cycle("t6.lw",    1'b1, e_lw(5'd2, 5'd1));
    set_add(5'd3, 5'd2, 5'd4);
    rst = 1'b1;                  cycle("t6.rst",   1'b0, e_bub());
    rst = 1'b0;                  cycle("t6.after", 1'b1, e_add(5'd3, 5'd2, 5'd4));

    if (sb.size() != 0) check("sb.residual", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
